// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared redirect-state, stage-control and latency defaults
package pipe_hazard_ctrl_pkg;
  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_DIV_LAT = 32;
  typedef enum logic {R_NONE, R_PEND} redir_state_t;
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } stage_ctrl_t;
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// md_busy_counter: HI/LO multi-cycle occupancy counter with registered busy flag
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic hold,
  output logic busy
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int W = $clog2(MAX_LAT + 1);
  logic [W-1:0] cnt, cnt_n;
  // the unit keeps counting under any stall; only a launch is gated by hold
  always_comb cnt_n = (start & ~hold) ? (is_div ? W'(DIV_LAT - 1) : W'(MUL_LAT - 1))
                    : (cnt != '0) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      busy <= cnt_n != '0;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush priority, delay-slot-aware redirect and mul/div busy
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        i_pending,
  input  logic        i_data_ok,
  input  logic        d_pending,
  input  logic        d_data_ok,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        md_busy
);
  redir_state_t state;
  stage_ctrl_t  sc;
  logic [31:0]  pend_pc;
  logic         mem_stall, fetch_stall, st_e, st_d, accept;
  assign mem_stall   = d_pending & ~d_data_ok;
  assign fetch_stall = i_pending & ~i_data_ok;
  assign st_e        = mem_stall | md_busy;
  assign st_d        = st_e | load_use;
  // each bubble is dropped when its target stage is frozen by a higher source
  assign sc = '{
    stall_f: st_d | fetch_stall,
    stall_d: st_d,
    stall_e: st_e,
    stall_m: mem_stall,
    flush_d: fetch_stall & ~st_d,
    flush_e: load_use & ~st_e,
    flush_m: md_busy & ~mem_stall,
    flush_w: mem_stall
  };
  assign {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w} = sc;
  assign accept         = br_taken & ~st_d;
  assign redirect_valid = (state == R_PEND) ? i_data_ok : accept & ~fetch_stall;
  assign redirect_pc    = !redirect_valid ? '0 : (state == R_PEND) ? pend_pc : br_target;
  // a slow fetch means the delay slot is still in flight; hold the target until it lands
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state   <= R_NONE;
      pend_pc <= '0;
    end else if (state == R_PEND) begin
      if (i_data_ok) state <= R_NONE;
    end else if (accept & fetch_stall) begin
      state   <= R_PEND;
      pend_pc <= br_target;
    end
  md_busy_counter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk    (clk),
    .resetn (resetn),
    .start  (md_start),
    .is_div (md_is_div),
    .hold   (st_e),
    .busy   (md_busy)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with an independent priority-chain reference model
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  localparam int ML = 3;
  localparam int DL = 32;
  logic clk = 1'b0, resetn = 1'b0;
  logic load_use, br_taken, i_pending, i_data_ok, d_pending, d_data_ok, md_start, md_is_div;
  logic [31:0] br_target, redirect_pc;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic redirect_valid, md_busy;
  typedef struct packed {
    logic [7:0]  ctl;
    logic        rv;
    logic [31:0] pc;
    logic        busy;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, m_cnt = 0;
  logic m_pend = 1'b0;
  logic [31:0] m_tgt = '0;

  pipe_hazard_ctrl #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .resetn(resetn), .load_use(load_use), .br_taken(br_taken), .br_target(br_target),
    .i_pending(i_pending), .i_data_ok(i_data_ok), .d_pending(d_pending), .d_data_ok(d_data_ok),
    .md_start(md_start), .md_is_div(md_is_div),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  task automatic idle();
    {load_use, br_taken, i_pending, i_data_ok, d_pending, d_data_ok, md_start, md_is_div} = '0;
    br_target = '0;
  endtask

  task automatic step();
    exp_t e, g;
    logic ms, fs, busy, acc;
    logic [3:0] st, fl;
    ms = d_pending & ~d_data_ok;
    fs = i_pending & ~i_data_ok;
    busy = m_cnt != 0;
    if (ms) begin st = 4'b1111; fl = 4'b0001; end
    else if (busy) begin st = 4'b1110; fl = 4'b0010; end
    else if (load_use) begin st = 4'b1100; fl = 4'b0100; end
    else if (fs) begin st = 4'b1000; fl = 4'b1000; end
    else begin st = 4'b0000; fl = 4'b0000; end
    acc = br_taken & ~st[2];
    e.ctl = {st, fl};
    e.busy = busy;
    e.rv = m_pend ? i_data_ok : acc & ~fs;
    e.pc = !e.rv ? 32'h0 : m_pend ? m_tgt : br_target;
    assert (!(md_start && busy)) else $error("md_start while busy");
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk("ctl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}), 32'(g.ctl));
    chk("redirect_valid", 32'(redirect_valid), 32'(g.rv));
    chk("redirect_pc", redirect_pc, g.pc);
    chk("md_busy", 32'(md_busy), 32'(g.busy));
    @(posedge clk);
    if (resetn) begin
      if (m_pend) m_pend = ~i_data_ok;
      else if (acc & fs) begin m_pend = 1'b1; m_tgt = br_target; end
      if (md_start & ~st[1]) m_cnt = md_is_div ? DL - 1 : ML - 1;
      else if (m_cnt > 0) m_cnt--;
    end
    #1;
  endtask

  initial begin
    idle();
    step();
    step();
    resetn = 1'b1;
    step();
    load_use = 1'b1; step();
    idle(); step();
    br_taken = 1'b1; br_target = 32'hBFC0_0100; step();
    idle(); step();
    br_taken = 1'b1; br_target = 32'h8000_0040; i_pending = 1'b1; step();
    br_taken = 1'b0; step(); step();
    i_data_ok = 1'b1; step();
    idle(); step();
    md_start = 1'b1; md_is_div = 1'b1; step();
    md_start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      load_use = (i >= 10 && i < 13);
      step();
    end
    idle(); step(); step();
    d_pending = 1'b1; md_start = 1'b1; step();
    d_data_ok = 1'b1; step();
    idle(); step(); step(); step();
    d_pending = 1'b1; load_use = 1'b1; br_taken = 1'b1; br_target = 32'h1234_5678; step(); step();
    d_data_ok = 1'b1; step();
    d_pending = 1'b0; d_data_ok = 1'b0; load_use = 1'b0; step();
    idle(); step();
    br_taken = 1'b1; br_target = 32'h1111_2220; i_pending = 1'b1; step();
    br_taken = 1'b0; md_start = 1'b1; md_is_div = 1'b1; step();
    md_start = 1'b0;
    repeat (14) step();
    resetn = 1'b0; m_cnt = 0; m_pend = 1'b0; m_tgt = '0; idle(); step();
    resetn = 1'b1; i_pending = 1'b1; i_data_ok = 1'b1; step();
    idle(); step();
    for (int i = 0; i < 300; i++) begin
      d_pending = ($urandom % 4) == 0;
      d_data_ok = $urandom % 2;
      i_pending = $urandom % 2;
      i_data_ok = $urandom % 2;
      load_use = ($urandom % 5) == 0;
      br_taken = ($urandom % 4) == 0;
      br_target = $urandom;
      md_start = (m_cnt == 0) && (($urandom % 8) == 0);
      md_is_div = $urandom % 2;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
